mem_arbiter: RTL

Blocking two-port memory arbiter that shares a single memory port between the TinyRV1 processor's instruction-fetch interface (port I) and data interface (port D). Sits between the processor's imem/dmem request/response ports and the single-ported test memory. Holds at most one transaction in flight, and uses round-robin arbitration when both ports request in the same cycle.

---
 rtl/mem_msg_pkg.sv | 26 ++
 rtl/Register.sv | 22 ++
 rtl/mem_arbiter_rr.sv | 36 +++
 rtl/mem_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/mem_msg_pkg.sv
// Shared types and constants for the two-port memory arbiter: FSM states,
// port ids, request types and the latched request record.
package mem_msg_pkg;

    localparam int MEM_ADDR_NBITS = 32;
    localparam int MEM_DATA_NBITS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef struct packed {
        logic                      req_type;
        logic [MEM_ADDR_NBITS-1:0] addr;
        logic [MEM_DATA_NBITS-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/Register.sv
// Generic enabled register with asynchronous active-low reset to a
// parameterised value.
module Register #(
    parameter int                 p_nbits = 1,
    parameter logic [p_nbits-1:0] p_reset = '0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic [p_nbits-1:0] d_i,
    output logic [p_nbits-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= p_reset;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Two-input round-robin grant; the last-grant pointer only advances when the
// grant is actually consumed (en_i), so a lone requester is never starved.
module RoundRobinArb2
    import mem_msg_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_q == PORT_I) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
        last_d = gnt_o[1] ? PORT_D : PORT_I;
    end

    // Reset pointer to I so the first contention goes to D.
    Register #(.p_nbits(1), .p_reset(PORT_I)) u_last (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .d_i    (last_d),
        .q_o    (last_q)
    );

endmodule

// File: rtl/mem_arbiter.sv
// Blocking arbiter sharing one memory port between the instruction (I) and
// data (D) ports; one transaction in flight, round-robin on contention.
module mem_arbiter
    import mem_msg_pkg::*;
#(
    parameter int p_addr_nbits = MEM_ADDR_NBITS,
    parameter int p_data_nbits = MEM_DATA_NBITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    imem_req_val,
    output logic                    imem_req_rdy,
    input  logic [p_addr_nbits-1:0] imem_req_addr,
    output logic                    imem_resp_val,
    output logic [p_data_nbits-1:0] imem_resp_data,
    input  logic                    dmem_req_val,
    output logic                    dmem_req_rdy,
    input  logic                    dmem_req_type,
    input  logic [p_addr_nbits-1:0] dmem_req_addr,
    input  logic [p_data_nbits-1:0] dmem_req_wdata,
    output logic                    dmem_resp_val,
    output logic [p_data_nbits-1:0] dmem_resp_data,
    output logic                    mem_req_val,
    input  logic                    mem_req_rdy,
    output logic                    mem_req_type,
    output logic [p_addr_nbits-1:0] mem_req_addr,
    output logic [p_data_nbits-1:0] mem_req_wdata,
    input  logic                    mem_resp_val,
    input  logic [p_data_nbits-1:0] mem_resp_data
);

    logic [1:0] state_raw;
    state_t     state_q;
    state_t     state_d;
    mem_req_t   req_q;
    mem_req_t   req_d;
    logic       owner_q;
    logic       owner_d;
    logic [1:0] arb_req;
    logic [1:0] gnt;
    logic       hs;
    logic       in_req;
    logic       resp_fire;

    assign state_q = state_t'(state_raw);

    // Requests are only visible to the arbiter in IDLE, which also keeps both
    // req_rdy low while a transaction is in flight.
    assign arb_req = (state_q == IDLE) ? {dmem_req_val, imem_req_val} : 2'b00;

    RoundRobinArb2 u_arb (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (hs),
        .req_i  (arb_req),
        .gnt_o  (gnt)
    );

    assign imem_req_rdy = gnt[0];
    assign dmem_req_rdy = gnt[1];
    assign hs           = |gnt;

    always_comb begin
        req_d   = req_q;
        owner_d = owner_q;
        if (gnt[1]) begin
            req_d.req_type = dmem_req_type;
            req_d.addr     = dmem_req_addr;
            req_d.wdata    = dmem_req_wdata;
            owner_d        = PORT_D;
        end else if (gnt[0]) begin
            req_d.req_type = MEM_READ;
            req_d.addr     = imem_req_addr;
            req_d.wdata    = '0;
            owner_d        = PORT_I;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = REQ;
            REQ:     if (mem_req_rdy) state_d = WAIT;
            WAIT:    if (mem_resp_val) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    Register #(.p_nbits($bits(mem_req_t)), .p_reset('0)) u_req (
        .clk_i (clk), .rst_ni (rst), .en_i (hs), .d_i (req_d), .q_o (req_q)
    );

    Register #(.p_nbits(1), .p_reset(PORT_I)) u_owner (
        .clk_i (clk), .rst_ni (rst), .en_i (hs), .d_i (owner_d), .q_o (owner_q)
    );

    Register #(.p_nbits(2), .p_reset(IDLE)) u_state (
        .clk_i (clk), .rst_ni (rst), .en_i (1'b1), .d_i (state_d), .q_o (state_raw)
    );

    assign in_req        = (state_q == REQ);
    assign mem_req_val   = in_req;
    assign mem_req_type  = in_req & req_q.req_type;
    assign mem_req_addr  = in_req ? req_q.addr  : '0;
    assign mem_req_wdata = in_req ? req_q.wdata : '0;

    // Responses outside WAIT are stray and dropped.
    assign resp_fire      = (state_q == WAIT) && mem_resp_val;
    assign imem_resp_val  = resp_fire && (owner_q == PORT_I);
    assign dmem_resp_val  = resp_fire && (owner_q == PORT_D);
    assign imem_resp_data = imem_resp_val ? mem_resp_data : '0;
    assign dmem_resp_data = (dmem_resp_val && (req_q.req_type == MEM_READ)) ? mem_resp_data : '0;

endmodule
